// File: rtl/uart_tx_frame_serializer_if.sv
// rtl/uart_tx_frame_serializer_if.sv - load/config/strobe inputs and line/status outputs of the UART TX serializer
interface uart_tx_frame_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic [CNT_W-1:0]      Data_Len;
  logic                  MSB_First;
  logic                  Stop2;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  Tick;
  logic                  TX_OUT;
  logic                  Busy;
  logic                  ser_done;
  logic                  frame_done;

  modport master (
    output P_DATA, Data_Valid, Data_Len, MSB_First, Stop2, PAR_EN, PAR_TYP, Tick,
    input  TX_OUT, Busy, ser_done, frame_done
  );

  modport slave (
    input  P_DATA, Data_Valid, Data_Len, MSB_First, Stop2, PAR_EN, PAR_TYP, Tick,
    output TX_OUT, Busy, ser_done, frame_done
  );
endinterface

// File: rtl/uart_tx_frame_serializer.sv
// rtl/uart_tx_frame_serializer.sv - UART TX frame serializer (start, 1..DATA_WIDTH data bits, parity, 1/2 stop)
// Parity bit support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  uart_tx_frame_serializer_if.slave   bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP1 = 3'd3,
    STOP2 = 3'd4
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd5
`endif
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [CNT_W-1:0]      r_len;
  logic                  r_msb;
  logic                  r_stop2;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_ser_done;
  logic                  r_frame_done;

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_load;
  logic                  w_ser_done_nxt;
  logic                  w_frame_done_nxt;
  logic                  w_tx_nxt;
  logic [CNT_W-1:0]      w_len_res;
  logic [CNT_W-1:0]      w_idx;
  logic                  w_bit;

`ifdef UART_TX_PARITY_EN
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  w_par_calc;

  // Parity covers only the bits that will actually be sent.
  always_comb begin
    w_par_calc = bus.PAR_TYP;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (CNT_W'(i) < w_len_res) begin
        w_par_calc = w_par_calc ^ bus.P_DATA[i];
      end
    end
  end
`else
  logic                  w_unused_par;
  assign w_unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  always_comb begin
    w_len_res = bus.Data_Len;
    if ((bus.Data_Len == '0) || (bus.Data_Len > LEN_MAX)) begin
      w_len_res = LEN_MAX;
    end
  end

  // Bit to present on the line for the counter value entering the next cycle.
  always_comb begin
    w_idx = r_msb ? (r_len - CNT_W'(1) - w_cnt_nxt) : w_cnt_nxt;
    w_bit = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (CNT_W'(i) == w_idx) begin
        w_bit = r_word[i];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_load           = 1'b0;
    w_ser_done_nxt   = 1'b0;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Data_Valid) begin
          w_load      = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (bus.Tick) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
        end
      end
      DATA: begin
        if (bus.Tick) begin
          if (r_cnt == (r_len - CNT_W'(1))) begin
            w_ser_done_nxt = 1'b1;
`ifdef UART_TX_PARITY_EN
            w_state_nxt    = r_par_en ? PARITY : STOP1;
`else
            w_state_nxt    = STOP1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bus.Tick) begin
          w_state_nxt = STOP1;
        end
      end
`endif
      STOP1: begin
        if (bus.Tick) begin
          if (r_stop2) begin
            w_state_nxt = STOP2;
          end else begin
            w_state_nxt      = IDLE;
            w_frame_done_nxt = 1'b1;
          end
        end
      end
      STOP2: begin
        if (bus.Tick) begin
          w_state_nxt      = IDLE;
          w_frame_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_bit;
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nxt = r_par_bit;
`endif
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_word       <= '0;
      r_len        <= '0;
      r_msb        <= 1'b0;
      r_stop2      <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_ser_done   <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en     <= 1'b0;
      r_par_bit    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tx         <= w_tx_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_ser_done   <= w_ser_done_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (w_load) begin
        r_word    <= bus.P_DATA;
        r_len     <= w_len_res;
        r_msb     <= bus.MSB_First;
        r_stop2   <= bus.Stop2;
`ifdef UART_TX_PARITY_EN
        r_par_en  <= bus.PAR_EN;
        r_par_bit <= w_par_calc;
`endif
      end
    end
  end

  assign bus.TX_OUT     = r_tx;
  assign bus.Busy       = r_busy;
  assign bus.ser_done   = r_ser_done;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// tb/tb_uart_tx_frame_serializer.sv - self-checking bench for uart_tx_frame_serializer
module tb_uart_tx_frame_serializer;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   exp_q[$];
  int   exp_nd;

  uart_tx_frame_serializer_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_frame_serializer #(.DATA_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: the whole frame as a list of line levels, one per bit period.
  function automatic void model_frame(input logic [7:0] data, input logic [3:0] lenf,
                                      input logic msb, input logic st2,
                                      input logic pen, input logic ptyp);
    int n;
    bit par;
    n = (lenf == 4'd0 || lenf > 4'd8) ? 8 : int'(lenf);
    exp_nd = n;
    exp_q.delete();
    exp_q.push_back(1'b0);
    par = ptyp;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(((data >> (msb ? (n - 1 - k) : k)) & 8'h01) != 8'h00);
      par = par ^ (((data >> k) & 8'h01) != 8'h00);
    end
    if (pen && PAR_BUILT) exp_q.push_back(par);
    exp_q.push_back(1'b1);
    if (st2) exp_q.push_back(1'b1);
  endfunction

  task automatic run_frame(input logic [7:0] data, input logic [3:0] lenf, input logic msb,
                           input logic st2, input logic pen, input logic ptyp,
                           input bit hold, input bit load_tick);
    int gap;
    logic [3:0] exp_o;
    logic [3:0] act;
    model_frame(data, lenf, msb, st2, pen, ptyp);
    bus.P_DATA     = data;
    bus.Data_Len   = lenf;
    bus.MSB_First  = msb;
    bus.Stop2      = st2;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = ptyp;
    bus.Data_Valid = 1'b1;
    bus.Tick       = load_tick;
    @(negedge clk);
    bus.Data_Valid = hold;
    bus.Tick       = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g <= gap; g++) begin
        exp_o = {exp_q[i], 1'b1, (i == exp_nd + 1 && g == 0), 1'b0};
        act   = {bus.TX_OUT, bus.Busy, bus.ser_done, bus.frame_done};
        tests_run++;
        if (act !== exp_o) begin
          tests_failed++;
          $display("FAIL frame_bit%0d (data=%h len=%0d msb=%0d): {tx,busy,ser_done,frame_done}=%b expected %b",
                   i, data, lenf, msb, act, exp_o);
        end
        if (hold) begin
          bus.P_DATA    = 8'($urandom);
          bus.Data_Len  = 4'($urandom);
          bus.MSB_First = 1'($urandom);
          bus.Stop2     = 1'($urandom);
          bus.PAR_EN    = 1'($urandom);
          bus.PAR_TYP   = 1'($urandom);
        end
        bus.Tick = (g == gap);
        @(negedge clk);
        bus.Tick = 1'b0;
      end
    end
    act = {bus.TX_OUT, bus.Busy, bus.ser_done, bus.frame_done};
    tests_run++;
    if (act !== 4'b1001) begin
      tests_failed++;
      $display("FAIL frame_end (data=%h): {tx,busy,ser_done,frame_done}=%b expected 1001", data, act);
    end
    bus.Data_Valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [3:0] act;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      act = {bus.TX_OUT, bus.Busy, bus.ser_done, bus.frame_done};
      tests_run++;
      if (act !== 4'b1000) begin
        tests_failed++;
        $display("FAIL idle: {tx,busy,ser_done,frame_done}=%b expected 1000", act);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] act;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    act = {bus.TX_OUT, bus.Busy, bus.ser_done, bus.frame_done};
    tests_run++;
    if (act !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_state: {tx,busy,ser_done,frame_done}=%b expected 1000", act);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_frames();
    run_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    run_frame(8'h0B, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_parity();
    run_frame(8'h07, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    run_frame(8'h07, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    run_frame(8'h5C, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_len_bounds();
    run_frame(8'h3C, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    run_frame(8'hC3, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    run_frame(8'h02, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_hold_valid();
    run_frame(8'h96, 4'd8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    run_frame(8'h69, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      run_frame(8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    end
    idle(1);
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] act;
    bus.P_DATA     = 8'hA5;
    bus.Data_Len   = 4'd8;
    bus.MSB_First  = 1'b0;
    bus.Stop2      = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    repeat (3) begin
      bus.Tick = 1'b1;
      @(negedge clk);
      bus.Tick = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    act = {bus.TX_OUT, bus.Busy, bus.ser_done, bus.frame_done};
    tests_run++;
    if (act !== 4'b1000) begin
      tests_failed++;
      $display("FAIL async_reset_mid_data: {tx,busy,ser_done,frame_done}=%b expected 1000", act);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    run_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      run_frame(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.Data_Len   = '0;
    bus.MSB_First  = 1'b0;
    bus.Stop2      = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Tick       = 1'b0;
    test_reset();
    test_basic_frames();
    test_parity();
    test_len_bounds();
    test_hold_valid();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
